// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Drives the hold/bubble controls of the PC, IF/ID, ID/EX and EX/MEM
//   registers from load-use hazards, EX-stage redirects and data-memory
//   wait states. Controls are combinational (zero latency). The stall and
//   flush performance counters saturate at all-ones.
// Ports
//   clk, reset (async, active-low)
//   id_rs, id_rt, id_uses_rt      : source registers of the instruction in ID
//   idex_mem_read, idex_rt        : load in EX and its destination register
//   ex_redirect                   : taken branch / resolved jump in EX
//   mem_busy                      : data memory not ready; whole pipe holds
//   pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush,
//   exmem_enable                  : pipeline register controls
//   stall_cycles                  : cycles with pc_enable=0
//   flush_events                  : redirects applied
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_enable,
  output logic             ifid_enable,
  output logic             ifid_flush,
  output logic             idex_enable,
  output logic             idex_flush,
  output logic             exmem_enable,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, FLUSH} state_t;

  state_t state, state_next;
  logic   pending_redirect, pending_next;
  logic   lu, redir, flush_inc;

  always_comb begin
    lu = idex_mem_read && (idex_rt != '0) &&
         ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
    redir = ex_redirect | pending_redirect;
  end

  always_comb begin
    pc_enable    = 1'b1;
    ifid_enable  = 1'b1;
    ifid_flush   = 1'b0;
    idex_enable  = 1'b1;
    idex_flush   = 1'b0;
    exmem_enable = 1'b1;
    state_next   = RUN;
    pending_next = 1'b0;
    flush_inc    = 1'b0;

    if (mem_busy) begin
      pc_enable    = 1'b0;
      ifid_enable  = 1'b0;
      idex_enable  = 1'b0;
      exmem_enable = 1'b0;
      // A redirect seen while memory holds the pipe is kept until release.
      pending_next = pending_redirect | ex_redirect;
      state_next   = MEM_WAIT;
    end else if (redir) begin
      // Pending and a same-cycle ex_redirect collapse into one flush.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_inc  = 1'b1;
      state_next = FLUSH;
    end else if (lu) begin
      pc_enable   = 1'b0;
      ifid_enable = 1'b0;
      idex_flush  = 1'b1;
      state_next  = LU_STALL;
    end

    // While reset is low the pipe must run freely regardless of inputs.
    if (!reset) begin
      pc_enable    = 1'b1;
      ifid_enable  = 1'b1;
      ifid_flush   = 1'b0;
      idex_enable  = 1'b1;
      idex_flush   = 1'b0;
      exmem_enable = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= RUN;
      pending_redirect <= 1'b0;
      stall_cycles     <= '0;
      flush_events     <= '0;
    end else begin
      state            <= state_next;
      pending_redirect <= pending_next;
      if (!pc_enable && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_inc && (flush_events != '1))
        flush_events <= flush_events + CNT_W'(1);
    end
  end

  // The state register is a trace of which priority row applied last;
  // outputs come from the priority table alone.
  logic unused_state;
  always_comb unused_state = ^state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Directed bench for pipeline_hazard_ctrl. A second instance with a 4-bit
//   counter width shares the same stimulus to exercise counter saturation.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, idex_rt;
  logic       id_uses_rt, idex_mem_read, ex_redirect, mem_busy;

  logic        pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush, exmem_enable;
  logic [15:0] stall_cycles, flush_events;
  logic        pc_enable4, ifid_enable4, ifid_flush4, idex_enable4, idex_flush4, exmem_enable4;
  logic [3:0]  stall_cycles4, flush_events4;

  int vectors = 0;
  int miscompares = 0;

  // control bit order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en
  localparam logic [5:0] C_RUN   = 6'b110101;
  localparam logic [5:0] C_MEM   = 6'b000000;
  localparam logic [5:0] C_REDIR = 6'b111111;
  localparam logic [5:0] C_LU    = 6'b000011;
  localparam logic [5:0] M_ALL   = 6'b111111;
  localparam logic [5:0] M_LU    = 6'b111011;

  logic [5:0] ctl;
  assign ctl = {pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush, exmem_enable};

  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .ex_redirect(ex_redirect),
    .mem_busy(mem_busy), .pc_enable(pc_enable), .ifid_enable(ifid_enable),
    .ifid_flush(ifid_flush), .idex_enable(idex_enable), .idex_flush(idex_flush),
    .exmem_enable(exmem_enable), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .ex_redirect(ex_redirect),
    .mem_busy(mem_busy), .pc_enable(pc_enable4), .ifid_enable(ifid_enable4),
    .ifid_flush(ifid_flush4), .idex_enable(idex_enable4), .idex_flush(idex_flush4),
    .exmem_enable(exmem_enable4), .stall_cycles(stall_cycles4), .flush_events(flush_events4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [5:0] exp, input logic [5:0] mask);
    chk(tag, {26'b0, ctl & mask}, {26'b0, exp & mask});
  endtask

  task automatic chk_cnt(input string tag, input int stalls, input int flushes);
    chk({tag, "_stall"}, {16'b0, stall_cycles}, stalls);
    chk({tag, "_flush"}, {16'b0, flush_events}, flushes);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; id_rs = '0; id_rt = '0; idex_rt = '0;
    id_uses_rt = 1'b0; idex_mem_read = 1'b0; ex_redirect = 1'b0; mem_busy = 1'b0;
    #1;
    chk_ctl("reset_ctl", C_RUN, M_ALL);
    chk_cnt("reset", 0, 0);

    // 1. idle after reset
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk_ctl("idle_ctl", C_RUN, M_ALL);
      chk_cnt("idle", 0, 0);
    end

    // 2. load-use on rs, single stall
    @(negedge clk); idex_mem_read = 1'b1; idex_rt = 5'd8; id_rs = 5'd8; #1;
    chk_ctl("lu_rs_ctl", C_LU, M_LU);
    @(negedge clk); idex_mem_read = 1'b0; #1;
    chk_cnt("lu_rs", 1, 0);
    chk_ctl("lu_rs_after", C_RUN, M_ALL);
    @(negedge clk); #1;
    chk_cnt("lu_rs_hold", 1, 0);

    // 3. no stall for r0 or for rt match when rt is unused
    idex_mem_read = 1'b1; idex_rt = 5'd0; id_rs = 5'd0; #1;
    chk_ctl("lu_r0", C_RUN, M_ALL);
    idex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd1; id_uses_rt = 1'b0; #1;
    chk_ctl("lu_rt_unused", C_RUN, M_ALL);
    // rt used: stall, held for two consecutive cycles
    id_uses_rt = 1'b1; #1;
    chk_ctl("lu_rt_used", C_LU, M_LU);
    @(negedge clk); #1;
    chk_cnt("lu_rt1", 2, 0);
    chk_ctl("lu_rt_second", C_LU, M_LU);
    @(negedge clk); idex_mem_read = 1'b0; id_uses_rt = 1'b0; #1;
    chk_cnt("lu_rt2", 3, 0);
    chk_ctl("lu_rt_clear", C_RUN, M_ALL);

    // 4. redirect pulse
    @(negedge clk); ex_redirect = 1'b1; #1;
    chk_ctl("redir_ctl", C_REDIR, M_ALL);
    @(negedge clk); ex_redirect = 1'b0; #1;
    chk_cnt("redir", 3, 1);
    chk_ctl("redir_after", C_RUN, M_ALL);

    // 5. mem_busy x3, redirect in the 2nd cycle, applied in the 4th
    @(negedge clk); mem_busy = 1'b1; #1;
    chk_ctl("mb_c1", C_MEM, M_ALL);
    @(negedge clk); ex_redirect = 1'b1; #1;
    chk_ctl("mb_c2", C_MEM, M_ALL);
    @(negedge clk); ex_redirect = 1'b0; #1;
    chk_ctl("mb_c3", C_MEM, M_ALL);
    @(negedge clk); mem_busy = 1'b0; #1;
    chk_ctl("mb_release", C_REDIR, M_ALL);
    chk_cnt("mb_wait", 6, 1);
    @(negedge clk); #1;
    chk_cnt("mb_done", 6, 2);
    chk_ctl("mb_run", C_RUN, M_ALL);

    // pending plus same-cycle ex_redirect counts once
    @(negedge clk); mem_busy = 1'b1; ex_redirect = 1'b1; #1;
    chk_ctl("dup_busy", C_MEM, M_ALL);
    @(negedge clk); mem_busy = 1'b0; #1;
    chk_ctl("dup_apply", C_REDIR, M_ALL);
    @(negedge clk); ex_redirect = 1'b0; #1;
    chk_cnt("dup", 7, 3);
    chk_ctl("dup_cleared", C_RUN, M_ALL);

    // 6. 20 stall cycles: 4-bit counter saturates
    @(negedge clk); mem_busy = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge clk);
    #1;
    chk_cnt("sat16", 27, 3);
    chk("sat4_stall", {28'b0, stall_cycles4}, 32'd15);
    chk("sat4_flush", {28'b0, flush_events4}, 32'd3);
    @(negedge clk); #1;
    chk("sat4_hold", {28'b0, stall_cycles4}, 32'd15);

    // reset mid-stall with a redirect pending
    ex_redirect = 1'b1;
    @(negedge clk); ex_redirect = 1'b0; #1;
    chk_ctl("pre_reset", C_MEM, M_ALL);
    reset = 1'b0; #1;
    chk_ctl("reset_mid", C_RUN, M_ALL);
    chk_cnt("reset_mid", 0, 0);
    @(negedge clk); mem_busy = 1'b0; reset = 1'b1; #1;
    chk_ctl("post_reset", C_RUN, M_ALL);
    @(negedge clk); #1;
    chk_cnt("post_reset", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
